// File: rtl/sobel_window_3x3_if.sv
// sobel_window_3x3_if: pixel stream, line-buffer port pair and edge-image output bundle.
interface sobel_window_3x3_if #(parameter int ADDR_WIDTH = 7);
    logic                  in_valid;
    logic [7:0]            in_pixel;
    logic [ADDR_WIDTH-1:0] lb_addr;
    logic                  lb0_we;
    logic [31:0]           lb0_wdata;
    logic [31:0]           lb0_rdata;
    logic                  lb1_we;
    logic [31:0]           lb1_wdata;
    logic [31:0]           lb1_rdata;
    logic                  out_valid;
    logic [7:0]            out_pixel;
    logic                  out_last;
    logic                  frame_done;

    modport master (
        input  in_valid, in_pixel, lb0_rdata, lb1_rdata,
        output lb_addr, lb0_we, lb0_wdata, lb1_we, lb1_wdata,
        output out_valid, out_pixel, out_last, frame_done
    );

    modport slave (
        output in_valid, in_pixel, lb0_rdata, lb1_rdata,
        input  lb_addr, lb0_we, lb0_wdata, lb1_we, lb1_wdata,
        input  out_valid, out_pixel, out_last, frame_done
    );
endinterface

// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3: 3x3 window over two chained line buffers, saturated |Gx|+|Gy| edge image.
module sobel_window_3x3 #(
    parameter int LINE_WIDTH = 73,
    parameter int LINE_COUNT = 48,
    parameter int ADDR_WIDTH = 7
) (
    input logic clk,
    input logic reset,
    sobel_window_3x3_if.master bus
);
    localparam int RW = $clog2(LINE_COUNT);

    logic [ADDR_WIDTH-1:0] col;
    logic [RW-1:0]         row;
    logic                  acc, col_end, row_end;
    logic                  s1_v, s2_v, s3_v, s1_q, s2_q, s3_q, s1_last, s2_last, s3_last;
    logic [7:0]            s1_pix;
    logic [2:0][2:0][7:0]  w;
    logic [9:0]            gxp, gxn, gyp, gyn, ax, ay;
    logic signed [10:0]    gx_c, gy_c, gx, gy;
    logic [10:0]           sum;

    assign acc     = bus.in_valid & ~reset;
    assign col_end = col == ADDR_WIDTH'(LINE_WIDTH - 1);
    assign row_end = row == RW'(LINE_COUNT - 1);

    // Buffer 1 commits its write to the address it latched on the accept cycle.
    assign bus.lb_addr    = acc ? col : '0;
    assign bus.lb0_we     = acc;
    assign bus.lb0_wdata  = {24'b0, bus.in_pixel};
    assign bus.lb1_we     = s1_v & ~reset;
    assign bus.lb1_wdata  = bus.lb0_rdata;
    assign bus.frame_done = acc & col_end & row_end;

    always_comb begin
        gxp  = 10'(w[0][2]) + {1'b0, w[1][2], 1'b0} + 10'(w[2][2]);
        gxn  = 10'(w[0][0]) + {1'b0, w[1][0], 1'b0} + 10'(w[2][0]);
        gyp  = 10'(w[2][0]) + {1'b0, w[2][1], 1'b0} + 10'(w[2][2]);
        gyn  = 10'(w[0][0]) + {1'b0, w[0][1], 1'b0} + 10'(w[0][2]);
        gx_c = $signed({1'b0, gxp}) - $signed({1'b0, gxn});
        gy_c = $signed({1'b0, gyp}) - $signed({1'b0, gyn});
        ax   = gx[10] ? 10'(-gx) : gx[9:0];
        ay   = gy[10] ? 10'(-gy) : gy[9:0];
        sum  = {1'b0, ax} + {1'b0, ay};
    end

    assign bus.out_pixel = reset ? 8'd0 : sum > 11'd255 ? 8'hff : sum[7:0];
    assign bus.out_valid = s3_v & s3_q & ~reset;
    assign bus.out_last  = bus.out_valid & s3_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            s1_last <= 1'b0;
            s2_last <= 1'b0;
            s3_last <= 1'b0;
            s1_pix  <= '0;
            w       <= '0;
            gx      <= '0;
            gy      <= '0;
        end else begin
            if (acc) begin
                col <= col_end ? '0 : col + 1'b1;
                row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
            end
            s1_v    <= acc;
            s1_pix  <= bus.in_pixel;
            s1_q    <= row >= RW'(2) && col >= ADDR_WIDTH'(2);
            s1_last <= col_end;
            s2_v    <= s1_v;
            s2_q    <= s1_q;
            s2_last <= s1_last;
            if (s1_v) begin
                for (int i = 0; i < 3; i++) begin
                    w[i][0] <= w[i][1];
                    w[i][1] <= w[i][2];
                end
                w[0][2] <= bus.lb1_rdata[7:0];
                w[1][2] <= bus.lb0_rdata[7:0];
                w[2][2] <= s1_pix;
            end
            s3_v    <= s2_v;
            s3_q    <= s2_q;
            s3_last <= s2_last;
            if (s2_v) begin
                gx <= gx_c;
                gy <= gy_c;
            end
        end
    end
endmodule

// File: tb/tb_sobel_window_3x3.sv
// tb_sobel_window_3x3: line-buffer model plus scoreboard of expected edge pixels and output cycles.
module tb_sobel_window_3x3;
    localparam int LW = 73;
    localparam int LC = 48;

    typedef struct {int cyc; int pix; int last;} exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] m0 [LW];
    logic [7:0] m1 [LW];
    logic [6:0] addr_q;
    int img [LC][LW];
    int checks = 0, fails = 0, cyc = 0;
    int dr = 0, dc = 0;
    int n_out = 0, n_last = 0, n_done = 0;
    logic prev_acc = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    sobel_window_3x3_if #(.ADDR_WIDTH(7)) bus();

    sobel_window_3x3 #(.LINE_WIDTH(LW), .LINE_COUNT(LC), .ADDR_WIDTH(7)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Read-before-write buffers; buffer 1 writes at the address presented one cycle earlier.
    always @(posedge clk) begin
        addr_q        <= bus.lb_addr;
        bus.lb0_rdata <= {24'b0, m0[bus.lb_addr]};
        bus.lb1_rdata <= {24'b0, m1[bus.lb_addr]};
        if (bus.lb0_we) m0[bus.lb_addr] <= bus.lb0_wdata[7:0];
        if (bus.lb1_we) m1[addr_q] <= bus.lb1_wdata[7:0];
    end

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int mag(int r, int c);
        int p [3][3];
        int gx, gy, m;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r - 2 + i][c - 2 + j];
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return m > 255 ? 255 : m;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic acc;
        cyc++;
        if (reset) begin
            q.delete();
            prev_acc = 1'b0;
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_out_last", int'(bus.out_last), 0);
            check("rst_out_pixel", int'(bus.out_pixel), 0);
            check("rst_lb0_we", int'(bus.lb0_we), 0);
            check("rst_lb1_we", int'(bus.lb1_we), 0);
            check("rst_lb_addr", int'(bus.lb_addr), 0);
            check("rst_frame_done", int'(bus.frame_done), 0);
        end else begin
            acc = bus.in_valid;
            check("lb0_we", int'(bus.lb0_we), int'(acc));
            check("lb1_we", int'(bus.lb1_we), int'(prev_acc));
            check("frame_done", int'(bus.frame_done), int'(acc && dr == LC - 1 && dc == LW - 1));
            if (acc) begin
                check("lb_addr", int'(bus.lb_addr), dc);
                check("lb0_wdata", int'(bus.lb0_wdata), img[dr][dc]);
                if (dr >= 2 && dc >= 2) q.push_back('{cyc + 3, mag(dr, dc), int'(dc == LW - 1)});
            end
            n_done += int'(bus.frame_done);
            if (bus.out_valid) begin
                n_out++;
                n_last += int'(bus.out_last);
                if (q.size() == 0) check("out_extra", int'(bus.out_valid), 0);
                else begin
                    e = q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_pixel", int'(bus.out_pixel), e.pix);
                    check("out_last", int'(bus.out_last), e.last);
                end
            end else check("out_last_idle", int'(bus.out_last), 0);
            prev_acc = acc;
        end
    end

    task automatic fill(int t);
        for (int r = 0; r < LC; r++)
            for (int c = 0; c < LW; c++)
                case (t)
                    0: img[r][c] = 100;
                    1: img[r][c] = c >= 36 ? 255 : 0;
                    2: img[r][c] = r >= 24 ? 40 : 0;
                    3: img[r][c] = (r == 5 && c == 5) ? 10 : 0;
                    default: img[r][c] = int'($urandom_range(255, 0));
                endcase
    endtask

    task automatic drive_frame(int gap, int stop_r, int stop_c);
        for (int r = 0; r < LC; r++)
            for (int c = 0; c < LW; c++) begin
                if (r == stop_r && c == stop_c) begin
                    bus.in_valid = 1'b0;
                    return;
                end
                while (gap != 0 && $urandom_range(1, 0) == 1) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                dr = r;
                dc = c;
                bus.in_pixel = 8'(img[r][c]);
                bus.in_valid = 1'b1;
                @(posedge clk); #1;
            end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_frame(string tag);
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_drain"}, q.size(), 0);
        check({tag, "_n_out"}, n_out, (LW - 2) * (LC - 2));
        check({tag, "_n_last"}, n_last, LC - 2);
        check({tag, "_n_done"}, n_done, 1);
        n_out = 0;
        n_last = 0;
        n_done = 0;
    endtask

    initial begin
        #1500000;
        $display("FAIL timeout got=%0d exp=0", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        fill(0); drive_frame(0, -1, -1); finish_frame("uniform");
        fill(1); drive_frame(0, -1, -1); finish_frame("vstep");
        fill(2); drive_frame(0, -1, -1); finish_frame("hstep");
        fill(3); drive_frame(0, -1, -1); finish_frame("single");
        fill(1); drive_frame(1, -1, -1); finish_frame("vstep_gaps");
        fill(4);
        drive_frame(0, 10, 40);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'hab;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_out = 0;
        n_last = 0;
        n_done = 0;
        drive_frame(0, -1, -1);
        finish_frame("after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/sobel_window_3x3.md
Name: sobel_window_3x3

Overview:
- Consumes a raster 8-bit grey pixel stream and drives two external line buffers as a chained pair: buffer 0 holds row r-1, buffer 1 holds row r-2.
- Assembles a 3x3 window from the incoming pixel and the two buffer read-backs.
- Computes the Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits.
- Sits directly downstream of the pixel source, owns line-buffer addressing and write strobes, and emits the edge image to the output formatter.

Parameters:
- LINE_WIDTH, 73, pixels per row; column counter runs 0..LINE_WIDTH-1.
- LINE_COUNT, 48, rows per frame; row counter runs 0..LINE_COUNT-1.
- ADDR_WIDTH, 7, width of line-buffer address; must hold LINE_WIDTH-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel present on in_pixel this cycle; gaps allowed.
- in_pixel  in  8  unsigned grey pixel.
- lb_addr  out  ADDR_WIDTH  column address shared by both line buffers.
- lb0_we  out  1  write strobe, line buffer 0.
- lb0_wdata  out  32  {24'b0, in_pixel}.
- lb0_rdata  in  32  buffer 0 read-back; pixel in bits [7:0].
- lb1_we  out  1  write strobe, line buffer 1.
- lb1_wdata  out  32  lb0_rdata forwarded (row r-1 pushed down).
- lb1_rdata  in  32  buffer 1 read-back; pixel in bits [7:0].
- out_valid  out  1  out_pixel valid this cycle.
- out_pixel  out  8  saturated Sobel magnitude.
- out_last  out  1  qualifies the last valid output of a row.
- frame_done  out  1  one-cycle pulse when the final pixel of a frame is accepted.

Behaviour:
- Reset: col=0, row=0, all pipeline valids=0, window regs=0.
- Reset outputs: lb_addr=0, lb0_we=0, lb1_we=0, out_valid=0, out_pixel=0, out_last=0, frame_done=0.
- Reset mid-frame discards all in-flight pixels; the next accepted pixel is (row 0, col 0).
- Line-buffer contract: with the address presented at cycle T (with or without a write), the rdata at T+1 is the value written at that address one row earlier (read-before-write).
- S0, accept (cycle T, in_valid=1):
  - lb_addr=col, lb0_we=1.
  - Register pixel, col, row.
  - lb_addr and we are combinational from in_valid and col.
- Stage 1 (T+1):
  - lb1_we=1 and lb1_wdata=lb0_rdata, at address col registered from T.
  - Window shifts left one column; new right column is {top=lb1_rdata[7:0], mid=lb0_rdata[7:0], bot=pixel from T}.
- Stage 2 (T+2): register Gx and Gy.
  - Gx = (p02 + 2·p12 + p22) - (p00 + 2·p10 + p20).
  - Gy = (p20 + 2·p21 + p22) - (p00 + 2·p01 + p02).
  - Index is row,col; col 2 is newest.
  - Partial sums are 10-bit unsigned; differences are 11-bit signed.
- Stage 3 (T+3): out_pixel = min(|Gx|+|Gy|, 255).
  - |G| is 10 bits; the sum is 11 bits.
- Latency: exactly 3 cycles, accept to out_valid.
- Gaps in in_valid: the window shifts only on stage-1-valid cycles; each stage's valid is simply delayed.
- Output qualification: out_valid only for accepted pixels with row>=2 and col>=2.
  - The window centre is (row-1, col-1).
  - Output image is (LINE_WIDTH-2)×(LINE_COUNT-2).
- out_last: asserted with out_valid when the source col==LINE_WIDTH-1.
- Column wrap: at col==LINE_WIDTH-1, col goes to 0 and row increments.
- Frame wrap: at row==LINE_COUNT-1 and col==LINE_WIDTH-1, row goes to 0 and frame_done pulses in the same cycle as the accept.
- Window left columns at a row start hold stale data; these outputs are suppressed by the col>=2 rule.

Test Plan:
- Uniform frame, all pixels 100, LINE_WIDTH=73, LINE_COUNT=48 -> exactly 3266 out_valid pulses, all out_pixel=0; 46 out_last pulses; 1 frame_done.
- Vertical step: cols 0..35 =0, cols 36..72 =255 -> out_pixel=255 (1020 saturated) for window centres 35 and 36, 0 elsewhere.
- Horizontal step: rows 0..23 =0, rows 24..47 =40 -> out_pixel=160 for centres on rows 23 and 24, 0 elsewhere.
- Single pixel 10 at (5,5), others 0 -> centres (4..6, 4..6) give 20 at the 4 side-adjacent centres, 20 at the 4 diagonals, and 0 at (5,5); first valid output at exactly 3 cycles after the (row 2, col 2) accept.
- Random in_valid gaps (~50% duty) on the step image -> output sequence identical to the gap-free run; lb0_we, lb1_we, out_valid and frame_done each pulse only for accepted pixels.
- Reset asserted at row 10, col 40, then a fresh frame -> no out_valid within 3 cycles of reset; next frame output is identical to the clean-run golden result.
